aes_key_mem_128: RTL and testbench
==================================

// Module: aes_key_mem_128
// PURPOSE
//  - Upstream key stage for the AES-128 encipher round datapath: expands a 128-bit cipher key into 11 round keys and stores them.
//  - Serves round_key[round] to the round datapath by combinational lookup.
//  - Shares the 32-bit S-box with the encipher datapath through sboxw/new_sboxw; the core mux gives the S-box to this block only while ready=0.
// PARAMETERS
//  - None configurable. localparam AES128_ROUNDS = 4'ha (round keys 0..10).
// PORTS
//  clk        in   1    clock, all state updates on posedge
//  reset_n    in   1    reset, asynchronous, active-low
//  init       in   1    start key expansion; single-cycle strobe
//  key        in   128  cipher key, sampled on the accepted init edge only
//  round      in   4    round-key index requested by the round datapath
//  round_key  out  128  stored round key for index `round`
//  ready      out  1    1 = idle and all 11 keys valid/stable
//  sboxw      out  32   word presented to the shared S-box
//  new_sboxw  in   32   S-box result, combinational from sboxw, same cycle
// BEHAVIOUR
//  - Reset (async): key_mem[0..10]=0, prev_key=0, round_ctr=0, rcon=8'h00, ready=1, state=IDLE.
//    Reset mid-expansion aborts; keys read 0 until the next completed init.
//  - State IDLE: init=1 is accepted only when ready=1. On that edge:
//    key_mem[0]<=key, prev_key<=key, round_ctr<=1, rcon<=8'h01, ready<=0, state<=GEN.
//  - State GEN: one round key per cycle. With prev_key={w0,w1,w2,w3}:
//    sboxw=w3; t={new_sboxw[23:0],new_sboxw[31:24]} ^ {rcon,24'h0}
//    k0=w0^t; k1=w1^k0; k2=w2^k1; k3=w3^k2
//    key_mem[round_ctr]<={k0,k1,k2,k3}; prev_key<= same; round_ctr++
//    rcon<={rcon[6:0],1'b0} ^ (8'h1b & {8{rcon[7]}})   (01,02,..,80,1b,36)
//    When round_ctr==10, the write is done and ready<=1, round_ctr<=0, state<=IDLE.
//  - Latency: ready is low for exactly 10 cycles after the init edge and rises on the 10th following edge (11 edges total incl. init).
//  - sboxw=32'h0 in IDLE. The S-box is used only in GEN.
//  - init while ready=0 is ignored; expansion continues unaffected.
//    init on the same edge ready rises: ignored (ready was 0 when sampled).
//  - round_key = key_mem[round] for round 0..10; round 11..15 -> 128'h0. Read is purely combinational, zero cycles.
//    During GEN, reads return stale or partially updated keys; consumers must wait for ready=1.
//  - key is not registered outside the accepted init edge; later changes on key have no effect.
//  - Re-init after completion overwrites all 11 entries. No partial retention.
//  - All arithmetic is GF(2^8)/XOR only; no width growth. round_ctr is 4 bits and never exceeds 10.
// TESTING
//  1. Reset, no init -> ready=1, round_key=0 for all rounds, sboxw=0.
//  2. FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c -> ready low 10 cycles;
//     round 0 = key; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
//  3. Key 0 -> round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
//  4. Second init with a different key pulsed at cycle 4 of an expansion -> ignored;
//     results match test 2, and ready rises at the same cycle.
//  5. reset_n low at cycle 5 of expansion -> ready=1 immediately and all keys read 0;
//     then a fresh init of the A.1 key -> test 2 values.
//  6. round=11..15 after a completed expansion -> round_key=0. Back-to-back init on the cycle after ready rises -> accepted; ready low for 10 cycles.

Source files
------------

// File: rtl/aes_key_mem_128_if.sv
// Key-memory port bundle between the AES core and the AES-128 key expansion block.
// The master side is the core; the slave side is the key memory.
interface aes_key_mem_128_if;
  logic         init;
  logic [127:0] key;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;

  modport master (
    output init, key, round, new_sboxw,
    input  round_key, ready, sboxw
  );

  modport slave (
    input  init, key, round, new_sboxw,
    output round_key, ready, sboxw
  );
endinterface

// File: rtl/aes_key_mem_128.sv
// AES-128 key expansion: builds and stores the 11 round keys, one per cycle, using the
// S-box shared with the encipher datapath, and serves round_key[round] combinationally.
module aes_key_mem_128 (
  input  logic                    clk,
  input  logic                    reset_n,
  aes_key_mem_128_if.slave        bus
);

  localparam logic [3:0] AES128_ROUNDS = 4'ha;

  typedef enum logic {IDLE, GEN} state_t;

  state_t       state, state_n;
  logic [3:0]   round_ctr, round_ctr_n;
  logic [7:0]   rcon, rcon_n;
  logic [127:0] prev_key, prev_key_n;
  logic         ready, ready_n;

  logic         mem_we;
  logic [3:0]   mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] key_mem [0:10];

  logic [31:0]  w0, w1, w2, w3, t, k0, k1, k2, k3;
  logic [31:0]  sboxw;

  assign w0 = prev_key[127:96];
  assign w1 = prev_key[95:64];
  assign w2 = prev_key[63:32];
  assign w3 = prev_key[31:0];

  // RotWord of the substituted word, then fold in the round constant.
  assign t  = {bus.new_sboxw[23:0], bus.new_sboxw[31:24]} ^ {rcon, 24'h0};
  assign k0 = w0 ^ t;
  assign k1 = w1 ^ k0;
  assign k2 = w2 ^ k1;
  assign k3 = w3 ^ k2;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      round_ctr <= 4'h0;
      rcon      <= 8'h00;
      prev_key  <= '0;
      ready     <= 1'b1;
    end else begin
      state     <= state_n;
      round_ctr <= round_ctr_n;
      rcon      <= rcon_n;
      prev_key  <= prev_key_n;
      ready     <= ready_n;
    end
  end

  // NOTE: the key array is reset because an aborted expansion must read back as all zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= 10; i++) key_mem[i] <= '0;
    end else if (mem_we) begin
      key_mem[mem_addr] <= mem_wdata;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_n     = state;
    round_ctr_n = round_ctr;
    rcon_n      = rcon;
    prev_key_n  = prev_key;
    ready_n     = ready;
    mem_we      = 1'b0;
    mem_addr    = 4'h0;
    mem_wdata   = prev_key;
    sboxw       = 32'h0;

    unique case (state)
      IDLE: begin
        if (bus.init && ready) begin
          mem_we      = 1'b1;
          mem_addr    = 4'h0;
          mem_wdata   = bus.key;
          prev_key_n  = bus.key;
          round_ctr_n = 4'h1;
          rcon_n      = 8'h01;
          ready_n     = 1'b0;
          state_n     = GEN;
        end
      end
      GEN: begin
        sboxw       = w3;
        mem_we      = 1'b1;
        mem_addr    = round_ctr;
        mem_wdata   = {k0, k1, k2, k3};
        prev_key_n  = {k0, k1, k2, k3};
        round_ctr_n = round_ctr + 4'h1;
        rcon_n      = {rcon[6:0], 1'b0} ^ (8'h1b & {8{rcon[7]}});
        if (round_ctr == AES128_ROUNDS) begin
          ready_n     = 1'b1;
          round_ctr_n = 4'h0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.sboxw     = sboxw;
  assign bus.ready     = ready;
  assign bus.round_key = (bus.round <= AES128_ROUNDS) ? key_mem[bus.round] : '0;

endmodule

// File: tb/tb_aes_key_mem_128.sv
// Directed bench for aes_key_mem_128: FIPS-197 key schedules, latency, ignored inits,
// mid-expansion reset and out-of-range reads, with an AES S-box model on the shared port.
module tb_aes_key_mem_128;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  aes_key_mem_128_if bus ();

  aes_key_mem_128 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [7:0] sbox_tab [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign bus.new_sboxw = {sbox_tab[bus.sboxw[31:24]], sbox_tab[bus.sboxw[23:16]],
                          sbox_tab[bus.sboxw[15:8]],  sbox_tab[bus.sboxw[7:0]]};

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R2    = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] A1_R9    = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] A1_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_R1     = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R2     = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] Z_R10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] KEY_ALT  = 128'h000102030405060708090a0b0c0d0e0f;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input string tag, input int r, input logic [127:0] exp);
    bus.round = 4'(r);
    #1;
    check($sformatf("%s_round%0d", tag, r), bus.round_key, exp);
  endtask

  // Init edge plus a scrambled key afterwards, so only the accepted edge may sample key.
  task automatic start(input logic [127:0] k);
    bus.key  = k;
    bus.init = 1'b1;
    tick();
    bus.init = 1'b0;
    bus.key  = 128'hdeadbeef_cafef00d_01234567_89abcdef;
  endtask

  // Counts edges after the init edge until ready; cnt_in covers edges already spent.
  task automatic wait_ready(input string tag, input int cnt_in);
    int cnt = cnt_in;
    while (!bus.ready && cnt < 40) begin
      tick();
      cnt++;
    end
    check({tag, "_latency"}, 128'(cnt), 128'd10);
  endtask

  task automatic check_a1(input string tag);
    read_check(tag, 0, KEY_A1);
    read_check(tag, 1, A1_R1);
    read_check(tag, 2, A1_R2);
    read_check(tag, 9, A1_R9);
    read_check(tag, 10, A1_R10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.init  = 1'b0;
    bus.key   = '0;
    bus.round = 4'h0;
    #12 reset_n = 1'b1;
    tick();

    // 1: reset state
    check("reset_ready", 128'(bus.ready), 128'd1);
    check("reset_sboxw", 128'(bus.sboxw), 128'd0);
    for (int r = 0; r < 16; r++) read_check("reset", r, '0);

    // 2: FIPS-197 A.1 key schedule
    start(KEY_A1);
    check("a1_ready_low", 128'(bus.ready), 128'd0);
    check("a1_sboxw_w3", 128'(bus.sboxw), 128'h09cf4f3c);
    wait_ready("a1", 0);
    check("a1_sboxw_idle", 128'(bus.sboxw), 128'd0);
    check_a1("a1");

    // 3: all-zero key
    start('0);
    wait_ready("zero", 0);
    read_check("zero", 0, '0);
    read_check("zero", 1, Z_R1);
    read_check("zero", 2, Z_R2);
    read_check("zero", 10, Z_R10);

    // 4: second init during expansion must be ignored
    start(KEY_A1);
    for (int i = 0; i < 3; i++) tick();
    bus.key  = KEY_ALT;
    bus.init = 1'b1;
    tick();
    bus.init = 1'b0;
    wait_ready("ign", 4);
    check_a1("ign");

    // init held on the edge where ready rises is also ignored
    start('0);
    for (int i = 0; i < 9; i++) tick();
    bus.key  = KEY_A1;
    bus.init = 1'b1;
    tick();
    bus.init = 1'b0;
    check("edge_ready", 128'(bus.ready), 128'd1);
    tick();
    check("edge_still_ready", 128'(bus.ready), 128'd1);
    read_check("edge", 0, '0);
    read_check("edge", 1, Z_R1);

    // 5: asynchronous reset mid-expansion
    start(KEY_A1);
    for (int i = 0; i < 4; i++) tick();
    #2 reset_n = 1'b0;
    #1;
    check("abort_ready", 128'(bus.ready), 128'd1);
    check("abort_sboxw", 128'(bus.sboxw), 128'd0);
    for (int r = 0; r <= 10; r++) read_check("abort", r, '0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    start(KEY_A1);
    wait_ready("rerun", 0);
    check_a1("rerun");

    // 6: out-of-range rounds, then back-to-back init right after ready rises
    for (int r = 11; r < 16; r++) read_check("oor", r, '0);
    start('0);
    wait_ready("b2b_first", 0);
    start(KEY_A1);
    check("b2b_ready_low", 128'(bus.ready), 128'd0);
    wait_ready("b2b", 0);
    check_a1("b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
